multicycle_control_fsm: RTL and testbench
=========================================

// Module: multicycle_control_fsm
// PURPOSE
//  Main controller for the multicycle RV32I-subset core. Sequences fetch, decode,
//  execute, memory and writeback. Drives IRWrite, which latches Instr and OldPC
//  in the instruction register, and all datapath select and enable lines.
//  Sits between the instruction register outputs (op/funct fields) and the datapath.
// PARAMETERS
//  USE_MEM_READY  0  1: FETCH/MEMREAD/MEMWRITE hold until MemReady=1; 0: MemReady ignored
// PORTS
//  clk          in   1  core clock, rising edge
//  reset        in   1  asynchronous, active-high; state -> FETCH immediately
//  op           in   7  Instr[6:0]
//  funct3       in   3  Instr[14:12]
//  funct7b5     in   1  Instr[30]
//  Zero         in   1  ALU zero flag
//  MemReady     in   1  memory access complete (only used if USE_MEM_READY=1)
//  PCWrite      out  1  (Branch & Zero) | PCUpdate
//  AdrSrc       out  1  0=PC, 1=Result
//  MemWrite     out  1  data memory write enable
//  IRWrite      out  1  latch Instr/OldPC
//  RegWrite     out  1  register file write enable
//  ResultSrc    out  2  00=ALUOut, 01=Data, 10=ALUResult
//  ALUSrcA      out  2  00=PC, 01=OldPC, 10=RD1(A)
//  ALUSrcB      out  2  00=RD2(WriteData), 01=ImmExt, 10=const 4
//  ImmSrc       out  2  00=I, 01=S, 10=B, 11=J (combinational from op)
//  ALUControl   out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
//  IllegalInstr out  1  one-cycle pulse in DECODE on unsupported op
// BEHAVIOUR
//  Moore FSM, outputs decoded from state only, except PCWrite (uses Zero),
//  ImmSrc/ALUControl (use op/funct) and IllegalInstr (uses op in DECODE).
//  Unlisted outputs are 0.
//  Reset: state=FETCH. While reset=1, PCWrite/IRWrite/RegWrite/MemWrite/IllegalInstr forced 0.
//  States/outputs (ALUOp internal, 2b):
//   FETCH    AdrSrc=0 IRWrite=1 A=00 B=10 ALUOp=00 ResultSrc=10 PCUpdate=1
//   DECODE   A=01 B=01 ALUOp=00 (branch target from OldPC)
//   MEMADR   A=10 B=01 ALUOp=00 | MEMREAD AdrSrc=1 ResultSrc=00
//   MEMWB    ResultSrc=01 RegWrite=1 | MEMWRITE AdrSrc=1 ResultSrc=00 MemWrite=1
//   EXECUTER A=10 B=00 ALUOp=10 | EXECUTEI A=10 B=01 ALUOp=10
//   ALUWB    ResultSrc=00 RegWrite=1
//   JAL      A=01 B=10 ALUOp=00 ResultSrc=00 PCUpdate=1
//   BEQ      A=10 B=00 ALUOp=01 ResultSrc=00 Branch=1
//  Transitions:
//   FETCH->DECODE
//   DECODE: 0000011,0100011->MEMADR; 0110011->EXECUTER; 0010011->EXECUTEI;
//           1101111->JAL; 1100011->BEQ; other->FETCH with IllegalInstr=1
//   MEMADR->MEMREAD if op[5]=0, else MEMWRITE
//   MEMREAD->MEMWB->FETCH; MEMWRITE->FETCH; EXECUTER/EXECUTEI/JAL->ALUWB->FETCH; BEQ->FETCH
//  Stall (USE_MEM_READY=1): FETCH/MEMREAD/MEMWRITE stay put while MemReady=0.
//   While stalled in FETCH: IRWrite=0 and PCUpdate=0, so PC and IR are not disturbed.
//   While stalled in MEMWRITE: MemWrite held 1; the write commits on the MemReady cycle.
//  ALU decode:
//   ALUOp 00->add; 01->sub; 10 by funct3: 000 add, or sub if op[5]&funct7b5;
//   010 slt; 110 or; 111 and; others add.
//  Latency (no stall): lw 5, sw 4, R/I 4, jal 4, beq 3 cycles.
//  Reset mid-instruction: abort, restart at FETCH; no partial RegWrite/MemWrite.
// STRUCTURE
//  Package ctrl_pkg: state_t enum (11 states), opcode localparams, ALUOp and
//  ALUControl encodings, ImmSrc encodings.
//  Sub-module alu_decoder (ALUOp, funct3, op[5], funct7b5 -> ALUControl).
//  FSM, PCWrite logic and ImmSrc decode stay in this module.
// TESTING
//  lw (op=0000011), USE_MEM_READY=0 -> states F,D,MA,MR,MWB; RegWrite=1 only in cycle 5;
//   ResultSrc=01 in cycle 5.
//  sub (op=0110011, f3=000, f7b5=1) -> ALUControl=001 in EXECUTER; RegWrite in cycle 4.
//  beq with Zero=1 -> PCWrite=1 in FETCH and in cycle 3.
//  beq with Zero=0 -> PCWrite=1 only in FETCH.
//  USE_MEM_READY=1, MemReady low 3 cycles in FETCH -> IRWrite=0 for 3 cycles,
//   then one IRWrite=1 pulse, then DECODE.
//  Reset asserted in MEMWRITE mid-cycle -> MemWrite drops immediately; state FETCH
//   after release; op=1111111 -> IllegalInstr pulse, back to FETCH.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle controller: FSM states, opcodes,
// ALUOp / ALUControl / ImmSrc codes and the supported-opcode check.
package ctrl_pkg;

    typedef enum logic [3:0] {
        StFetch    = 4'd0,
        StDecode   = 4'd1,
        StMemAdr   = 4'd2,
        StMemRead  = 4'd3,
        StMemWb    = 4'd4,
        StMemWrite = 4'd5,
        StExecuteR = 4'd6,
        StExecuteI = 4'd7,
        StAluWb    = 4'd8,
        StJal      = 4'd9,
        StBeq      = 4'd10
    } state_t;

    localparam logic [6:0] OpLoad  = 7'b0000011;
    localparam logic [6:0] OpStore = 7'b0100011;
    localparam logic [6:0] OpRType = 7'b0110011;
    localparam logic [6:0] OpIType = 7'b0010011;
    localparam logic [6:0] OpJal   = 7'b1101111;
    localparam logic [6:0] OpBeq   = 7'b1100011;

    typedef enum logic [1:0] {
        AluOpAdd   = 2'b00,
        AluOpSub   = 2'b01,
        AluOpFunct = 2'b10
    } alu_op_t;

    localparam logic [2:0] AluAdd = 3'b000;
    localparam logic [2:0] AluSub = 3'b001;
    localparam logic [2:0] AluAnd = 3'b010;
    localparam logic [2:0] AluOr  = 3'b011;
    localparam logic [2:0] AluSlt = 3'b101;

    localparam logic [1:0] ImmI = 2'b00;
    localparam logic [1:0] ImmS = 2'b01;
    localparam logic [1:0] ImmB = 2'b10;
    localparam logic [1:0] ImmJ = 2'b11;

    function automatic logic is_legal_op(input logic [6:0] op);
        case (op)
            OpLoad, OpStore, OpRType, OpIType, OpJal, OpBeq: is_legal_op = 1'b1;
            default:                                         is_legal_op = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// ALU decoder: maps the controller's ALUOp plus funct fields to ALUControl.
module alu_decoder
    import ctrl_pkg::*;
(
    input  alu_op_t     i_alu_op,
    input  logic [2:0]  i_funct3,
    input  logic        i_op_b5,
    input  logic        i_funct7b5,
    output logic [2:0]  o_alu_control
);

    // Decode ALU function; funct3 only matters for register/immediate ALU ops
    always_comb begin
        o_alu_control = AluAdd;
        case (i_alu_op)
            AluOpAdd: o_alu_control = AluAdd;
            AluOpSub: o_alu_control = AluSub;
            AluOpFunct: begin
                case (i_funct3)
                    // sub only for R-type (op[5]=1); addi never subtracts
                    3'b000:  o_alu_control = (i_op_b5 & i_funct7b5) ? AluSub : AluAdd;
                    3'b010:  o_alu_control = AluSlt;
                    3'b110:  o_alu_control = AluOr;
                    3'b111:  o_alu_control = AluAnd;
                    default: o_alu_control = AluAdd;
                endcase
            end
            default: o_alu_control = AluAdd;
        endcase
    end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Main controller for the multicycle RV32I-subset core: sequences
// fetch/decode/execute/memory/writeback and drives datapath selects/enables.
module multicycle_control_fsm
    import ctrl_pkg::*;
#(
    parameter bit USE_MEM_READY = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       Zero,
    input  logic       MemReady,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ImmSrc,
    output logic [2:0] ALUControl,
    output logic       IllegalInstr
);

    state_t  r_state;
    alu_op_t w_alu_op;
    logic    w_mem_ok;
    logic    w_pc_update;
    logic    w_branch;
    logic    w_ir_write;
    logic    w_reg_write;
    logic    w_mem_write;
    logic    w_illegal;

    // Memory handshake is bypassed entirely when MemReady is not in use
    assign w_mem_ok = !USE_MEM_READY || MemReady;

    // State register and transitions; reset aborts any instruction in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= StFetch;
        end else begin
            case (r_state)
                StFetch:    if (w_mem_ok) r_state <= StDecode;
                StDecode: begin
                    case (op)
                        OpLoad, OpStore: r_state <= StMemAdr;
                        OpRType:         r_state <= StExecuteR;
                        OpIType:         r_state <= StExecuteI;
                        OpJal:           r_state <= StJal;
                        OpBeq:           r_state <= StBeq;
                        default:         r_state <= StFetch;
                    endcase
                end
                StMemAdr:   r_state <= op[5] ? StMemWrite : StMemRead;
                StMemRead:  if (w_mem_ok) r_state <= StMemWb;
                StMemWb:    r_state <= StFetch;
                StMemWrite: if (w_mem_ok) r_state <= StFetch;
                StExecuteR: r_state <= StAluWb;
                StExecuteI: r_state <= StAluWb;
                StJal:      r_state <= StAluWb;
                StAluWb:    r_state <= StFetch;
                StBeq:      r_state <= StFetch;
                default:    r_state <= StFetch;
            endcase
        end
    end

    // Moore decode of datapath controls from the current state
    always_comb begin
        w_pc_update = 1'b0;
        w_branch    = 1'b0;
        w_ir_write  = 1'b0;
        w_reg_write = 1'b0;
        w_mem_write = 1'b0;
        w_illegal   = 1'b0;
        w_alu_op    = AluOpAdd;
        AdrSrc      = 1'b0;
        ResultSrc   = 2'b00;
        ALUSrcA     = 2'b00;
        ALUSrcB     = 2'b00;
        case (r_state)
            StFetch: begin
                ALUSrcB     = 2'b10;
                ResultSrc   = 2'b10;
                // A stalled fetch must leave PC and IR untouched
                w_ir_write  = w_mem_ok;
                w_pc_update = w_mem_ok;
            end
            StDecode: begin
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b01;
                w_illegal = !is_legal_op(op);
            end
            StMemAdr: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
            end
            StMemRead: begin
                AdrSrc = 1'b1;
            end
            StMemWb: begin
                ResultSrc   = 2'b01;
                w_reg_write = 1'b1;
            end
            StMemWrite: begin
                AdrSrc      = 1'b1;
                w_mem_write = 1'b1;
            end
            StExecuteR: begin
                ALUSrcA  = 2'b10;
                w_alu_op = AluOpFunct;
            end
            StExecuteI: begin
                ALUSrcA  = 2'b10;
                ALUSrcB  = 2'b01;
                w_alu_op = AluOpFunct;
            end
            StAluWb: begin
                w_reg_write = 1'b1;
            end
            StJal: begin
                ALUSrcA     = 2'b01;
                ALUSrcB     = 2'b10;
                w_pc_update = 1'b1;
            end
            StBeq: begin
                ALUSrcA  = 2'b10;
                w_alu_op = AluOpSub;
                w_branch = 1'b1;
            end
            default: ;
        endcase
    end

    // Immediate format follows the opcode directly, independent of state
    always_comb begin
        case (op)
            OpStore: ImmSrc = ImmS;
            OpBeq:   ImmSrc = ImmB;
            OpJal:   ImmSrc = ImmJ;
            default: ImmSrc = ImmI;
        endcase
    end

    // Write enables are forced low for the whole reset pulse
    assign PCWrite      = !reset && ((w_branch && Zero) || w_pc_update);
    assign IRWrite      = !reset && w_ir_write;
    assign RegWrite     = !reset && w_reg_write;
    assign MemWrite     = !reset && w_mem_write;
    assign IllegalInstr = !reset && w_illegal;

    alu_decoder u_alu_decoder (
        .i_alu_op      (w_alu_op),
        .i_funct3      (funct3),
        .i_op_b5       (op[5]),
        .i_funct7b5    (funct7b5),
        .o_alu_control (ALUControl)
    );

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Bench for multicycle_control_fsm: one instance without and one with the
// MemReady handshake, each tracked by a cycle-of-instruction model.
module tb_multicycle_control_fsm;

    localparam logic [6:0] LW   = 7'b0000011;
    localparam logic [6:0] SW   = 7'b0100011;
    localparam logic [6:0] RTY  = 7'b0110011;
    localparam logic [6:0] ITY  = 7'b0010011;
    localparam logic [6:0] JAL  = 7'b1101111;
    localparam logic [6:0] BEQ  = 7'b1100011;

    logic       clk;
    logic       reset;
    logic [6:0] op   [2];
    logic [2:0] f3   [2];
    logic       f7   [2];
    logic       zero [2];
    logic       mr   [2];
    logic       pcw  [2];
    logic       adr  [2];
    logic       mw   [2];
    logic       irw  [2];
    logic       rw   [2];
    logic [1:0] rs   [2];
    logic [1:0] sa   [2];
    logic [1:0] sb   [2];
    logic [1:0] imm  [2];
    logic [2:0] aluc [2];
    logic       ill  [2];

    int n_checks = 0;
    int n_fail   = 0;
    int m_k [2]  = '{0, 0};

    multicycle_control_fsm #(.USE_MEM_READY(1'b0)) dut0 (
        .clk(clk), .reset(reset), .op(op[0]), .funct3(f3[0]), .funct7b5(f7[0]),
        .Zero(zero[0]), .MemReady(mr[0]), .PCWrite(pcw[0]), .AdrSrc(adr[0]),
        .MemWrite(mw[0]), .IRWrite(irw[0]), .RegWrite(rw[0]), .ResultSrc(rs[0]),
        .ALUSrcA(sa[0]), .ALUSrcB(sb[0]), .ImmSrc(imm[0]), .ALUControl(aluc[0]),
        .IllegalInstr(ill[0])
    );

    multicycle_control_fsm #(.USE_MEM_READY(1'b1)) dut1 (
        .clk(clk), .reset(reset), .op(op[1]), .funct3(f3[1]), .funct7b5(f7[1]),
        .Zero(zero[1]), .MemReady(mr[1]), .PCWrite(pcw[1]), .AdrSrc(adr[1]),
        .MemWrite(mw[1]), .IRWrite(irw[1]), .RegWrite(rw[1]), .ResultSrc(rs[1]),
        .ALUSrcA(sa[1]), .ALUSrcB(sb[1]), .ImmSrc(imm[1]), .ALUControl(aluc[1]),
        .IllegalInstr(ill[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic bit legal(input logic [6:0] o);
        return (o == LW) || (o == SW) || (o == RTY) || (o == ITY) || (o == JAL) || (o == BEQ);
    endfunction

    // Total cycles an instruction occupies without stalls
    function automatic int instr_len(input logic [6:0] o);
        if (o == LW) return 5;
        if (o == SW || o == RTY || o == ITY || o == JAL) return 4;
        if (o == BEQ) return 3;
        return 2;
    endfunction

    // Cycles that wait on memory: fetch, and the load/store data access
    function automatic bit is_stall(input int i, input logic [6:0] o, input int k,
                                    input logic ready);
        if (i == 0 || ready) return 1'b0;
        return (k == 0) || (k == 3 && (o == LW || o == SW));
    endfunction

    function automatic logic [2:0] alu_fn(input logic [6:0] o, input logic [2:0] fn3,
                                         input logic fn7);
        case (fn3)
            3'b000:  return (o[5] && fn7) ? 3'b001 : 3'b000;
            3'b010:  return 3'b101;
            3'b110:  return 3'b011;
            3'b111:  return 3'b010;
            default: return 3'b000;
        endcase
    endfunction

    // Expected outputs {PCWrite,AdrSrc,MemWrite,IRWrite,RegWrite,ResultSrc,A,B,Imm,ALU,Ill}
    function automatic logic [16:0] expect_out(input logic [6:0] o, input logic [2:0] fn3,
                                               input logic fn7, input int k, input logic z,
                                               input bit stall, input logic rst);
        logic p, a, m, ir, r, il;
        logic [1:0] res, srca, srcb, im;
        logic [2:0] alu;
        {p, a, m, ir, r, il} = '0;
        res = 2'b00; srca = 2'b00; srcb = 2'b00; alu = 3'b000;
        im = (o == SW) ? 2'b01 : (o == BEQ) ? 2'b10 : (o == JAL) ? 2'b11 : 2'b00;
        if (k == 0) begin
            ir = !stall; p = !stall; srcb = 2'b10; res = 2'b10;
        end else if (k == 1) begin
            srca = 2'b01; srcb = 2'b01; il = !legal(o);
        end else if (o == LW || o == SW) begin
            if (k == 2) begin srca = 2'b10; srcb = 2'b01; end
            else if (k == 3) begin a = 1'b1; m = (o == SW); end
            else begin res = 2'b01; r = 1'b1; end
        end else if (o == RTY || o == ITY) begin
            if (k == 2) begin
                srca = 2'b10; srcb = (o == ITY) ? 2'b01 : 2'b00; alu = alu_fn(o, fn3, fn7);
            end else r = 1'b1;
        end else if (o == JAL) begin
            if (k == 2) begin srca = 2'b01; srcb = 2'b10; p = 1'b1; end
            else r = 1'b1;
        end else if (o == BEQ) begin
            srca = 2'b10; alu = 3'b001; p = z;
        end
        if (rst) {p, ir, r, m, il} = '0;
        return {p, a, m, ir, r, res, srca, srcb, im, alu, il};
    endfunction

    function automatic int next_k(input int i, input logic [6:0] o, input int k,
                                  input logic ready);
        if (is_stall(i, o, k, ready)) return k;
        return (k + 1 >= instr_len(o)) ? 0 : k + 1;
    endfunction

    // Model progress through each instruction; reset restarts immediately
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_k[0] <= 0;
            m_k[1] <= 0;
        end else begin
            m_k[0] <= next_k(0, op[0], m_k[0], mr[0]);
            m_k[1] <= next_k(1, op[1], m_k[1], mr[1]);
        end
    end

    // Compare every output of both instances against the model each cycle
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            check($sformatf("model_dut%0d_k%0d", i, m_k[i]),
                  32'({pcw[i], adr[i], mw[i], irw[i], rw[i], rs[i], sa[i], sb[i],
                       imm[i], aluc[i], ill[i]}),
                  32'(expect_out(op[i], f3[i], f7[i], m_k[i], zero[i],
                                 is_stall(i, op[i], m_k[i], mr[i]), reset)));
        end
    end

    task automatic set_instr(input logic [6:0] o, input logic [2:0] fn3, input logic fn7);
        for (int i = 0; i < 2; i++) begin
            op[i] = o; f3[i] = fn3; f7[i] = fn7;
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            op[i] = LW; f3[i] = 3'b000; f7[i] = 1'b0; zero[i] = 1'b0; mr[i] = 1'b1;
        end
        repeat (2) @(posedge clk);
        #1;
        check("reset_irwrite", 32'(irw[0]), 32'd0);
        check("reset_pcwrite", 32'(pcw[0]), 32'd0);

        // lw: RegWrite and ResultSrc=Data only in cycle 5
        reset = 1'b0;
        set_instr(LW, 3'b010, 1'b0);
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            check("lw_regwrite", 32'(rw[0]), 32'(c == 5));
            if (c == 1) check("lw_fetch_irwrite", 32'(irw[0]), 32'd1);
            if (c == 5) check("lw_resultsrc", 32'(rs[0]), 32'd1);
            next_cycle();
        end

        // sub: ALUControl=sub in execute, RegWrite in cycle 4
        set_instr(RTY, 3'b000, 1'b1);
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            if (c == 3) check("sub_alucontrol", 32'(aluc[0]), 32'd1);
            check("sub_regwrite", 32'(rw[0]), 32'(c == 4));
            next_cycle();
        end

        // beq taken then not taken
        zero[0] = 1'b1; zero[1] = 1'b1;
        set_instr(BEQ, 3'b000, 1'b0);
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            check("beq_taken_pcwrite", 32'(pcw[0]), 32'(c != 2));
            next_cycle();
        end
        zero[0] = 1'b0; zero[1] = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            check("beq_not_taken_pcwrite", 32'(pcw[0]), 32'(c == 1));
            next_cycle();
        end

        // sw interrupted by reset while writing
        set_instr(SW, 3'b010, 1'b0);
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            check("sw_memwrite", 32'(mw[0]), 32'(c == 4));
            if (c == 4) begin
                #2 reset = 1'b1;
                #1 check("reset_kills_memwrite", 32'(mw[0]), 32'd0);
                check("reset_kills_regwrite", 32'(rw[0]), 32'd0);
            end else begin
                next_cycle();
            end
        end
        next_cycle();
        reset = 1'b0;

        // Unsupported opcode pulses IllegalInstr in decode
        set_instr(7'b1111111, 3'b000, 1'b0);
        for (int c = 1; c <= 2; c++) begin
            @(negedge clk);
            if (c == 1) check("after_reset_fetch_irwrite", 32'(irw[0]), 32'd1);
            check("illegal_pulse", 32'(ill[0]), 32'(c == 2));
            next_cycle();
        end

        // Fetch stall on the handshake instance
        set_instr(ITY, 3'b110, 1'b0);
        mr[1] = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            if (c == 1) check("illegal_back_to_fetch", 32'(irw[0]), 32'd1);
            check("stall_irwrite", 32'(irw[1]), 32'd0);
            check("stall_pcwrite", 32'(pcw[1]), 32'd0);
            next_cycle();
        end
        mr[1] = 1'b1;
        @(negedge clk);
        check("stall_release_irwrite", 32'(irw[1]), 32'd1);
        next_cycle();
        @(negedge clk);
        check("stall_then_decode_srca", 32'(sa[1]), 32'd1);
        next_cycle();

        // Random instruction streams with random Zero, MemReady and resets
        for (int c = 0; c < 3000; c++) begin
            if (reset) reset = 1'b0;
            for (int i = 0; i < 2; i++) begin
                if (m_k[i] == 0) begin
                    case ($urandom_range(0, 6))
                        0: op[i] = LW;
                        1: op[i] = SW;
                        2: op[i] = RTY;
                        3: op[i] = ITY;
                        4: op[i] = JAL;
                        5: op[i] = BEQ;
                        default: op[i] = 7'($urandom);
                    endcase
                    f3[i] = 3'($urandom);
                    f7[i] = 1'($urandom);
                end
                zero[i] = 1'($urandom);
                mr[i]   = ($urandom_range(0, 3) != 0);
            end
            if ($urandom_range(0, 79) == 0) begin
                #3 reset = 1'b1;
            end
            next_cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
